// File: rtl/alu_byte_sequencer.sv
// alu_byte_sequencer
// Runs a WIDTH-bit AND/OR/ADD/SUB on a shared 8-bit ALU slice. It handles one
// byte per cycle, least-significant byte first, and passes the carry from each
// byte into the next.
//
// Ports
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   flush           synchronous abort; returns to IDLE and drops any work
//   req_*           request channel: operands A/B and the 4-bit op
//   resp_*          response channel: result, carry, zero and overflow flags
//   alu_a/b/cin/op  registered drive to the 8-bit slice
//   alu_result/cout combinational return from the slice
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// req_ready is high only in IDLE. resp_valid is high only in DONE, and the
// resp_* fields stay constant until resp_ready is seen. flush takes priority
// over both handshakes.
module alu_byte_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [3:0]       req_op,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_carry,
  output logic             resp_zero,
  output logic             resp_overflow,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic             alu_cin,
  output logic [3:0]       alu_op,
  input  logic [7:0]       alu_result,
  input  logic             alu_cout
);

  localparam int NBYTES = WIDTH / 8;
  localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic [3:0]       op_q;
  logic             req_ready_q, resp_valid_q;
  logic             resp_carry_q, resp_zero_q, resp_ovf_q;
  logic [7:0]       alu_a_q, alu_b_q;
  logic             alu_cin_q;

  // Result with the byte the slice is producing this cycle merged in.
  logic [WIDTH-1:0] res_d;
  logic [CW-1:0]    cnt_d;
  logic             is_last;
  logic             ovf_d;

  always_comb begin
    res_d = res_q;
    res_d[{cnt_q, 3'b000} +: 8] = alu_result;
    cnt_d   = cnt_q + 1'b1;
    is_last = (cnt_q == CW'(NBYTES - 1));
    ovf_d   = 1'b0;
    if (op_q == OP_ADD)
      ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_d[WIDTH-1] != a_q[WIDTH-1]);
    else if (op_q == OP_SUB)
      ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res_d[WIDTH-1] != a_q[WIDTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      carry_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      res_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_carry_q <= 1'b0;
      resp_zero_q  <= 1'b0;
      resp_ovf_q   <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_cin_q    <= 1'b0;
    end else if (flush) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            a_q         <= req_a;
            b_q         <= req_b;
            op_q        <= req_op;
            cnt_q       <= '0;
            // SUB is A + ~B + 1: the slice inverts B and the +1 enters here.
            carry_q     <= (req_op == OP_SUB);
            // Byte 0 is registered here, so the request has no
            // combinational path to the slice.
            alu_a_q     <= req_a[7:0];
            alu_b_q     <= req_b[7:0];
            alu_cin_q   <= (req_op == OP_SUB);
            req_ready_q <= 1'b0;
            state_q     <= EXEC;
          end
        end
        EXEC: begin
          res_q   <= res_d;
          carry_q <= alu_cout;
          cnt_q   <= cnt_d;
          if (is_last) begin
            state_q      <= DONE;
            cnt_q        <= '0;
            resp_valid_q <= 1'b1;
            resp_carry_q <= alu_cout;
            resp_zero_q  <= ~|res_d;
            resp_ovf_q   <= ovf_d;
          end else begin
            // Queue up the next byte. After the last byte these registers
            // keep their final values.
            alu_a_q   <= a_q[{cnt_d, 3'b000} +: 8];
            alu_b_q   <= b_q[{cnt_d, 3'b000} +: 8];
            alu_cin_q <= alu_cout;
          end
        end
        DONE: begin
          if (resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready     = req_ready_q;
  assign resp_valid    = resp_valid_q;
  assign resp_result   = res_q;
  assign resp_carry    = resp_carry_q;
  assign resp_zero     = resp_zero_q;
  assign resp_overflow = resp_ovf_q;
  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign alu_cin       = alu_cin_q;
  assign alu_op        = op_q;

endmodule

// File: tb/tb_alu_byte_sequencer.sv
// Directed testbench for alu_byte_sequencer, including a behavioural model of
// the 8-bit ALU slice that it drives.
module tb_alu_byte_sequencer;

  localparam int WIDTH  = 32;
  localparam int NBYTES = WIDTH / 8;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic             flush, req_valid, req_ready, resp_valid, resp_ready;
  logic [WIDTH-1:0] req_a, req_b, resp_result;
  logic [3:0]       req_op, alu_op;
  logic             resp_carry, resp_zero, resp_overflow;
  logic [7:0]       alu_a, alu_b, alu_result;
  logic             alu_cin, alu_cout;

  alu_byte_sequencer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_carry(resp_carry),
    .resp_zero(resp_zero), .resp_overflow(resp_overflow),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op),
    .alu_result(alu_result), .alu_cout(alu_cout)
  );

  // ---------------- 8-bit slice model ----------------
  logic [8:0] slice_sum;
  always_comb begin
    slice_sum  = 9'd0;
    alu_result = alu_a;
    alu_cout   = 1'b0;
    case (alu_op)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: begin
        slice_sum  = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
        alu_result = slice_sum[7:0];
        alu_cout   = slice_sum[8];
      end
      4'b0110: begin
        slice_sum  = {1'b0, alu_a} + {1'b0, ~alu_b} + {8'd0, alu_cin};
        alu_result = slice_sum[7:0];
        alu_cout   = slice_sum[8];
      end
      default: alu_result = alu_a;
    endcase
  end

  // ---------------- scoreboard counters ----------------
  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Golden 32-bit model: returns {overflow, zero, carry, result}.
  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] op);
    logic [32:0] s;
    logic        ov;
    s  = 33'd0;
    ov = 1'b0;
    if (op == OP_ADD) begin
      s  = {1'b0, a} + {1'b0, b};
      ov = (a[31] == b[31]) && (s[31] != a[31]);
    end else if (op == OP_SUB) begin
      s  = {1'b0, a} + {1'b0, ~b} + 33'd1;
      ov = (a[31] != b[31]) && (s[31] != a[31]);
    end
    return {ov, (s[31:0] == 32'd0), s[32], s[31:0]};
  endfunction

  // ---------------- driver tasks ----------------
  logic [31:0] cur_a, cur_b;
  logic [3:0]  cur_op;

  // Called at a negedge while IDLE; returns at the first negedge of EXEC.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    chk("issue_req_ready", req_ready, 1'b1);
    cur_a = a; cur_b = b; cur_op = op;
    req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("exec_req_ready", req_ready, 1'b0);
  endtask

  // Waits for resp_valid, checking the bytes sent to the slice on the way.
  task automatic wait_resp(input string tag, input logic [31:0] er, input logic ec,
                           input logic chk_c, input logic ez, input logic eo);
    int n;
    n = 0;
    while (!resp_valid && n < 20) begin
      if (n < NBYTES) begin
        chk({tag, "_alu_a"}, alu_a, cur_a[8*n +: 8]);
        chk({tag, "_alu_b"}, alu_b, cur_b[8*n +: 8]);
      end
      if (n == 0) begin
        chk({tag, "_alu_cin0"}, alu_cin, (cur_op == OP_SUB));
        chk({tag, "_alu_op"}, alu_op, cur_op);
      end
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, NBYTES);
    chk({tag, "_result"}, resp_result, er);
    if (chk_c) chk({tag, "_carry"}, resp_carry, ec);
    chk({tag, "_zero"}, resp_zero, ez);
    chk({tag, "_ovf"}, resp_overflow, eo);
  endtask

  task automatic release_resp();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("release_resp_valid", resp_valid, 1'b0);
    chk("release_req_ready", req_ready, 1'b1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [34:0] m;
    int          n;
    int          last_acc;
    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    req_a = '0; req_b = '0; req_op = '0;
    cur_a = '0; cur_b = '0; cur_op = '0;
    repeat (2) @(negedge clk);

    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_result", resp_result, 32'd0);
    chk("rst_carry", resp_carry, 1'b0);
    chk("rst_zero", resp_zero, 1'b0);
    chk("rst_ovf", resp_overflow, 1'b0);
    chk("rst_alu_a", alu_a, 8'd0);
    chk("rst_alu_b", alu_b, 8'd0);
    chk("rst_alu_cin", alu_cin, 1'b0);
    chk("rst_alu_op", alu_op, 4'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // ADD with carry ripple into byte 1
    issue(32'h0000_00FF, 32'h0000_0001, OP_ADD);
    wait_resp("add_ripple", 32'h0000_0100, 1'b0, 1'b1, 1'b0, 1'b0);
    release_resp();

    // SUB with borrow through every byte, then a non-borrowing SUB
    issue(32'h0, 32'h1, OP_SUB);
    wait_resp("sub_borrow", 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0);
    release_resp();
    issue(32'd5, 32'd3, OP_SUB);
    wait_resp("sub_5_3", 32'h0000_0002, 1'b1, 1'b1, 1'b0, 1'b0);
    release_resp();

    // Signed overflow; wrap to zero
    issue(32'h7FFF_FFFF, 32'h1, OP_ADD);
    wait_resp("add_ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
    release_resp();
    issue(32'hFFFF_FFFF, 32'h1, OP_ADD);
    wait_resp("add_zero", 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    release_resp();

    // AND, then hold the response under backpressure for 5 cycles
    issue(32'hF0F0_A5A5, 32'h0FF0_FF00, OP_AND);
    wait_resp("and", 32'h00F0_A500, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_resp_valid", resp_valid, 1'b1);
      chk("bp_result", resp_result, 32'h00F0_A500);
      chk("bp_req_ready", req_ready, 1'b0);
    end
    release_resp();

    // A flush in IDLE blocks the request
    req_a = 32'h1234_5678; req_b = 32'h1; req_op = OP_ADD;
    req_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    chk("idle_flush_req_ready", req_ready, 1'b1);
    @(negedge clk);
    chk("idle_flush_still_idle", req_ready, 1'b1);
    chk("idle_flush_no_resp", resp_valid, 1'b0);

    // A flush while byte 2 is in the slice cancels the operation
    issue(32'h1122_3344, 32'h0101_0101, OP_ADD);
    repeat (2) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("exec_flush_req_ready", req_ready, 1'b1);
    chk("exec_flush_resp_valid", resp_valid, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("exec_flush_no_resp", resp_valid, 1'b0);
    end
    issue(32'd3, 32'd4, OP_ADD);
    wait_resp("add_3_4", 32'd7, 1'b0, 1'b1, 1'b0, 1'b0);

    // A flush in DONE drops the result even though resp_ready is high
    flush = 1'b1; resp_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; resp_ready = 1'b0;
    chk("done_flush_resp_valid", resp_valid, 1'b0);
    chk("done_flush_req_ready", req_ready, 1'b1);

    // Asynchronous reset in the middle of EXEC
    issue(32'hA5A5_A5A5, 32'h5A5A_5A5A, OP_SUB);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req_ready", req_ready, 1'b1);
    chk("arst_resp_valid", resp_valid, 1'b0);
    chk("arst_result", resp_result, 32'd0);
    chk("arst_carry", resp_carry, 1'b0);
    chk("arst_zero", resp_zero, 1'b0);
    chk("arst_ovf", resp_overflow, 1'b0);
    chk("arst_alu_a", alu_a, 8'd0);
    chk("arst_alu_b", alu_b, 8'd0);
    chk("arst_alu_cin", alu_cin, 1'b0);
    chk("arst_alu_op", alu_op, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back random ADD/SUB with resp_ready held high
    resp_ready = 1'b1;
    last_acc   = 0;
    for (int i = 0; i < 8; i++) begin
      cur_a  = $urandom;
      cur_b  = $urandom;
      cur_op = ($urandom_range(0, 1) == 1) ? OP_ADD : OP_SUB;
      m      = model(cur_a, cur_b, cur_op);
      chk("b2b_req_ready", req_ready, 1'b1);
      req_a = cur_a; req_b = cur_b; req_op = cur_op; req_valid = 1'b1;
      if (i > 0) chk("b2b_period", cyc - last_acc, NBYTES + 2);
      last_acc = cyc;
      @(negedge clk);
      n = 0;
      while (!resp_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("b2b_latency", n, NBYTES);
      chk("b2b_result", resp_result, m[31:0]);
      chk("b2b_carry", resp_carry, m[32]);
      chk("b2b_zero", resp_zero, m[33]);
      chk("b2b_ovf", resp_overflow, m[34]);
      @(negedge clk);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    chk("b2b_end_req_ready", req_ready, 1'b1);
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/alu_byte_sequencer.md
Name: alu_byte_sequencer

Overview:
- Multi-cycle controller that executes WIDTH-bit ALU operations on the shared 8-bit ALU slice, one byte per cycle, least-significant byte first.
- Drives the slice's operand, carry-in and op inputs and chains carry between bytes.
- Assembles the full result and the flags, and returns them over a valid/ready response.
- Sits between execute-stage issue logic and the 8-bit ALU instance; used where area matters more than single-cycle ALU latency.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of 8, minimum 16.
- NBYTES, WIDTH/8, derived byte count; not overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort from pipeline control.
- req_valid  in  1  operation request valid.
- req_ready  out  1  controller can accept a request.
- req_a  in  WIDTH  operand A.
- req_b  in  WIDTH  operand B.
- req_op  in  4  ALU op: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB; other codes pass through.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- resp_result  out  WIDTH  assembled result.
- resp_carry  out  1  carry-out of the most-significant byte.
- resp_zero  out  1  resp_result == 0.
- resp_overflow  out  1  signed overflow; ADD/SUB only, else 0.
- alu_a  out  8  byte to slice operand a.
- alu_b  out  8  byte to slice operand b.
- alu_cin  out  1  slice carry-in.
- alu_op  out  4  slice op.
- alu_result  in  8  slice result, combinational.
- alu_cout  in  1  slice carry-out, combinational.

Behaviour:
- States are IDLE, EXEC and DONE.
- Reset (async, rst_n=0) forces:
  - state IDLE, byte counter 0, carry reg 0;
  - req_ready=1, resp_valid=0;
  - resp_result=0, resp_carry=0, resp_zero=0, resp_overflow=0;
  - alu_a=0, alu_b=0, alu_cin=0, alu_op=0.
- IDLE:
  - req_ready=1.
  - On req_valid && !flush: latch A, B and op; clear the counter; go to EXEC.
  - Initial carry reg = 1 if op==0110, else 0.
- EXEC:
  - req_ready=0.
  - Each cycle: alu_a = A byte[cnt], alu_b = B byte[cnt], alu_cin = carry reg, alu_op = latched op.
  - The slice inverts b for SUB internally; the controller never inverts it.
  - At each clock edge: capture alu_result into result byte[cnt], capture alu_cout into the carry reg, then cnt+1.
  - After byte NBYTES-1 is captured, go to DONE.
  - Slice outputs are driven from registered state only; no request-to-slice combinational path.
- DONE:
  - resp_valid=1 and all resp_* fields stable.
  - resp_carry = final carry reg.
  - resp_zero = ~|resp_result.
  - resp_overflow, ADD: A[MSB]==B[MSB] && R[MSB]!=A[MSB].
  - resp_overflow, SUB: A[MSB]!=B[MSB] && R[MSB]!=A[MSB].
  - On resp_ready: go to IDLE. A new request can be accepted in the next cycle; there is no same-cycle turnaround.
- Latency:
  - Request accepted at edge 0; resp_valid asserted after edge NBYTES (edge 4 at default).
  - Throughput is one operation per NBYTES+2 cycles with resp_ready held high.
- Backpressure: DONE holds indefinitely while resp_ready=0; outputs do not change.
- Carry chain is for ADD/SUB. For logic ops the carry is still chained but meaningless; resp_carry reports it raw and consumers must ignore it.
- flush:
  - In any state: next state IDLE, resp_valid=0, counter 0, no response produced.
  - flush overrides req_valid in IDLE, so the request is not accepted.
  - flush overrides resp_ready in DONE, so the result is dropped.
- Reset mid-EXEC or mid-DONE: immediate return to reset values; the partial result is discarded.
- alu_* outputs hold their last values outside EXEC. Don't-care for the slice, but deterministic.

Test Plan:
- ADD carry ripple: A=0x000000FF, B=0x00000001, op=0010. Response 4 cycles after accept: result=0x00000100, carry=0, zero=0, overflow=0.
- SUB borrow: A=0, B=1, op=0110 gives result=0xFFFFFFFF, carry=0, overflow=0. Then A=5, B=3 gives 0x00000002, carry=1.
- Overflow and zero:
  - 0x7FFFFFFF+0x00000001 ADD gives 0x80000000, overflow=1.
  - 0xFFFFFFFF+0x00000001 ADD gives 0x00000000, carry=1, zero=1, overflow=0.
- Logic and backpressure: AND of 0xF0F0A5A5 and 0x0FF0FF00 gives 0x00F0A500, overflow=0. Hold resp_ready=0 for 5 cycles: resp_valid stays 1 with a stable result, and req_ready stays 0 throughout.
- Flush and reset:
  - flush asserted at EXEC byte 2: no resp_valid; req_ready=1 the next cycle; the following ADD 3+4 returns 7.
  - rst_n pulsed low mid-EXEC: all outputs go to reset values asynchronously.
- Back-to-back: 8 random ADD/SUB ops with resp_ready=1. Each result matches a golden model, and accepts occur exactly every NBYTES+2 cycles.
